// File: rtl/synth_param_stager.sv
// Shadow/held staging of synth parameters with a four-phase req/ack commit toward the CDC.
// Optional ack watchdog enabled by defining SYNTH_STAGE_TIMEOUT_EN.
//
// state    | meaning
// ST_IDLE  | no transfer; commit or pending snapshots shadows into held outputs
// ST_REQ   | req high, waiting for ack to rise
// ST_REL   | req low, waiting for ack to fall; done pulses on exit
module synth_param_stager #(
   parameter int N_VOICES       = 4,
   parameter int FCW_W          = 24,
   parameter int SHIFT_W        = 5,
   parameter int TIMEOUT_CYCLES = 1024,
   localparam int ADDR_W        = $clog2(N_VOICES + 4)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        wr_en,
   input  logic [ADDR_W-1:0]           wr_addr,
   input  logic [31:0]                 wr_data,
   input  logic                        commit,
   input  logic                        ack,
   output logic                        req,
   output logic [N_VOICES*FCW_W-1:0]   out_carrier_fcws,
   output logic [FCW_W-1:0]            out_mod_fcw,
   output logic [SHIFT_W-1:0]          out_mod_shift,
   output logic [N_VOICES-1:0]         out_note_en,
   output logic [SHIFT_W-1:0]          out_synth_shift,
   output logic                        busy,
   output logic                        done,
   output logic                        timeout_err
);

   localparam logic [ADDR_W-1:0] A_MOD_FCW     = ADDR_W'(N_VOICES);
   localparam logic [ADDR_W-1:0] A_MOD_SHIFT   = ADDR_W'(N_VOICES + 1);
   localparam logic [ADDR_W-1:0] A_NOTE_EN     = ADDR_W'(N_VOICES + 2);
   localparam logic [ADDR_W-1:0] A_SYNTH_SHIFT = ADDR_W'(N_VOICES + 3);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_REL  = 2'd2
   } state_t;

   state_t state_q, state_d;
   logic   pending_q, pending_d;
   logic   done_q, done_d;
   logic   load;

   logic [N_VOICES*FCW_W-1:0] sh_carrier_q, sh_carrier_d;
   logic [FCW_W-1:0]          sh_mod_fcw_q, sh_mod_fcw_d;
   logic [SHIFT_W-1:0]        sh_mod_shift_q, sh_mod_shift_d;
   logic [N_VOICES-1:0]       sh_note_en_q, sh_note_en_d;
   logic [SHIFT_W-1:0]        sh_synth_shift_q, sh_synth_shift_d;

   logic [N_VOICES*FCW_W-1:0] hd_carrier_q;
   logic [FCW_W-1:0]          hd_mod_fcw_q;
   logic [SHIFT_W-1:0]        hd_mod_shift_q;
   logic [N_VOICES-1:0]       hd_note_en_q;
   logic [SHIFT_W-1:0]        hd_synth_shift_q;

   // Only the field-width low bits of wr_data are ever stored.
   logic unused_wr_data;
   assign unused_wr_data = ^wr_data;

   // Next-shadow values feed the snapshot so a same-cycle write is captured.
   always_comb begin
      sh_carrier_d     = sh_carrier_q;
      sh_mod_fcw_d     = sh_mod_fcw_q;
      sh_mod_shift_d   = sh_mod_shift_q;
      sh_note_en_d     = sh_note_en_q;
      sh_synth_shift_d = sh_synth_shift_q;
      if (wr_en) begin
         for (int i = 0; i < N_VOICES; i++) begin
            if (wr_addr == ADDR_W'(i)) sh_carrier_d[i*FCW_W +: FCW_W] = wr_data[FCW_W-1:0];
         end
         if (wr_addr == A_MOD_FCW)     sh_mod_fcw_d     = wr_data[FCW_W-1:0];
         if (wr_addr == A_MOD_SHIFT)   sh_mod_shift_d   = wr_data[SHIFT_W-1:0];
         if (wr_addr == A_NOTE_EN)     sh_note_en_d     = wr_data[N_VOICES-1:0];
         if (wr_addr == A_SYNTH_SHIFT) sh_synth_shift_d = wr_data[SHIFT_W-1:0];
      end
   end

`ifdef SYNTH_STAGE_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0] tmo_cnt_q;
   logic             tmo_hit;
   logic             tmo_fire;
   logic             timeout_err_q;
   assign tmo_hit = (state_q != ST_IDLE) && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
   logic [31:0] unused_tmo;
   assign unused_tmo = 32'(TIMEOUT_CYCLES);
`endif

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      done_d    = 1'b0;
      load      = 1'b0;
`ifdef SYNTH_STAGE_TIMEOUT_EN
      tmo_fire  = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (commit || pending_q) begin
               load      = 1'b1;
               pending_d = 1'b0;
               state_d   = ST_REQ;
            end
         end
         ST_REQ: begin
            if (commit) pending_d = 1'b1;
            if (ack) state_d = ST_REL;
         end
         ST_REL: begin
            if (commit) pending_d = 1'b1;
            if (!ack) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
`ifdef SYNTH_STAGE_TIMEOUT_EN
      // A handshake step landing on the limit cycle wins over the watchdog.
      if (tmo_hit && state_d == state_q) begin
         state_d   = ST_IDLE;
         pending_d = 1'b0;
         done_d    = 1'b0;
         tmo_fire  = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q          <= ST_IDLE;
         pending_q        <= 1'b0;
         done_q           <= 1'b0;
         sh_carrier_q     <= '0;
         sh_mod_fcw_q     <= '0;
         sh_mod_shift_q   <= '0;
         sh_note_en_q     <= '0;
         sh_synth_shift_q <= '0;
         hd_carrier_q     <= '0;
         hd_mod_fcw_q     <= '0;
         hd_mod_shift_q   <= '0;
         hd_note_en_q     <= '0;
         hd_synth_shift_q <= '0;
      end else begin
         state_q          <= state_d;
         pending_q        <= pending_d;
         done_q           <= done_d;
         sh_carrier_q     <= sh_carrier_d;
         sh_mod_fcw_q     <= sh_mod_fcw_d;
         sh_mod_shift_q   <= sh_mod_shift_d;
         sh_note_en_q     <= sh_note_en_d;
         sh_synth_shift_q <= sh_synth_shift_d;
         if (load) begin
            hd_carrier_q     <= sh_carrier_d;
            hd_mod_fcw_q     <= sh_mod_fcw_d;
            hd_mod_shift_q   <= sh_mod_shift_d;
            hd_note_en_q     <= sh_note_en_d;
            hd_synth_shift_q <= sh_synth_shift_d;
         end
      end
   end

`ifdef SYNTH_STAGE_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tmo_cnt_q     <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         if (state_d != state_q || state_q == ST_IDLE) tmo_cnt_q <= '0;
         else                                         tmo_cnt_q <= tmo_cnt_q + 1'b1;
         if (tmo_fire) timeout_err_q <= 1'b1;
      end
   end
   assign timeout_err = timeout_err_q;
`else
   assign timeout_err = 1'b0;
`endif

   assign req              = (state_q == ST_REQ);
   assign busy             = (state_q != ST_IDLE) || pending_q;
   assign done             = done_q;
   assign out_carrier_fcws = hd_carrier_q;
   assign out_mod_fcw      = hd_mod_fcw_q;
   assign out_mod_shift    = hd_mod_shift_q;
   assign out_note_en      = hd_note_en_q;
   assign out_synth_shift  = hd_synth_shift_q;

endmodule

// File: tb/tb_synth_param_stager.sv
// Directed bench for synth_param_stager: vector table plus hand sequences for
// queued commits, reset mid-transfer and the ack watchdog.
module tb_synth_param_stager;
   localparam int NV = 5;
   localparam int FW = 24;
   localparam int SW = 5;
   localparam int AW = $clog2(NV + 4);

   logic            clk = 1'b0;
   logic            rst_n;
   logic            wr_en;
   logic [AW-1:0]   wr_addr;
   logic [31:0]     wr_data;
   logic            commit;
   logic            ack;
   logic            req;
   logic [NV*FW-1:0] out_carrier_fcws;
   logic [FW-1:0]   out_mod_fcw;
   logic [SW-1:0]   out_mod_shift;
   logic [NV-1:0]   out_note_en;
   logic [SW-1:0]   out_synth_shift;
   logic            busy;
   logic            done;
   logic            timeout_err;

   always #5 clk = ~clk;

   synth_param_stager #(
      .N_VOICES(NV), .FCW_W(FW), .SHIFT_W(SW), .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .commit(commit), .ack(ack), .req(req), .out_carrier_fcws(out_carrier_fcws),
      .out_mod_fcw(out_mod_fcw), .out_mod_shift(out_mod_shift), .out_note_en(out_note_en),
      .out_synth_shift(out_synth_shift), .busy(busy), .done(done), .timeout_err(timeout_err)
   );

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [31:0]   data;
      logic          cm;
      logic          ak;
      logic          e_req;
      logic          e_done;
      logic          e_busy;
      logic [FW-1:0] e_c0;
      logic [FW-1:0] e_mfcw;
      logic [SW-1:0] e_msh;
      logic [NV-1:0] e_note;
      logic [SW-1:0] e_ssh;
   } vec_t;

   int n_vec = 0;
   int n_err = 0;

   function automatic vec_t mk(logic we, int addr, logic [31:0] data, logic cm, logic ak,
                               logic rq, logic dn, logic bz, logic [FW-1:0] c0,
                               logic [FW-1:0] mf, logic [SW-1:0] ms, logic [NV-1:0] ne,
                               logic [SW-1:0] ss);
      vec_t v;
      v.we = we; v.addr = AW'(addr); v.data = data; v.cm = cm; v.ak = ak;
      v.e_req = rq; v.e_done = dn; v.e_busy = bz; v.e_c0 = c0;
      v.e_mfcw = mf; v.e_msh = ms; v.e_note = ne; v.e_ssh = ss;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic we, input int addr, input logic [31:0] data,
                      input logic cm, input logic ak);
      wr_en = we; wr_addr = AW'(addr); wr_data = data; commit = cm; ack = ak;
   endtask

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   vec_t vt[17];

   initial begin
      int cnt, dcnt, rcnt, dbl;
      logic r1, r2, pd, saw_done;

      vt[0]  = mk(1, 0,      32'h0012_3456, 0, 0, 0, 0, 0, 24'h0,      24'h0, 5'h00, 5'h0, 5'h0);
      vt[1]  = mk(1, NV + 2, 32'h0000_000F, 0, 0, 0, 0, 0, 24'h0,      24'h0, 5'h00, 5'h0, 5'h0);
      vt[2]  = mk(0, 0,      32'h0,         1, 0, 1, 0, 1, 24'h123456, 24'h0, 5'h00, 5'hF, 5'h0);
      vt[3]  = mk(0, 0,      32'h0,         0, 0, 1, 0, 1, 24'h123456, 24'h0, 5'h00, 5'hF, 5'h0);
      vt[4]  = mk(0, 0,      32'h0,         0, 0, 1, 0, 1, 24'h123456, 24'h0, 5'h00, 5'hF, 5'h0);
      vt[5]  = mk(0, 0,      32'h0,         0, 1, 0, 0, 1, 24'h123456, 24'h0, 5'h00, 5'hF, 5'h0);
      vt[6]  = mk(0, 0,      32'h0,         0, 1, 0, 0, 1, 24'h123456, 24'h0, 5'h00, 5'hF, 5'h0);
      vt[7]  = mk(0, 0,      32'h0,         0, 0, 0, 1, 0, 24'h123456, 24'h0, 5'h00, 5'hF, 5'h0);
      vt[8]  = mk(0, 0,      32'h0,         0, 0, 0, 0, 0, 24'h123456, 24'h0, 5'h00, 5'hF, 5'h0);
      vt[9]  = mk(1, NV + 4, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 24'h123456, 24'h0, 5'h00, 5'hF, 5'h0);
      vt[10] = mk(1, NV + 1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 24'h123456, 24'h0, 5'h00, 5'hF, 5'h0);
      vt[11] = mk(1, NV + 3, 32'h0000_0003, 1, 0, 1, 0, 1, 24'h123456, 24'h0, 5'h1F, 5'hF, 5'h3);
      vt[12] = mk(0, 0,      32'h0,         0, 1, 0, 0, 1, 24'h123456, 24'h0, 5'h1F, 5'hF, 5'h3);
      vt[13] = mk(0, 0,      32'h0,         0, 0, 0, 1, 0, 24'h123456, 24'h0, 5'h1F, 5'hF, 5'h3);
      vt[14] = mk(0, 0,      32'h0,         0, 0, 0, 0, 0, 24'h123456, 24'h0, 5'h1F, 5'hF, 5'h3);
      vt[15] = mk(0, 0,      32'h0,         0, 1, 0, 0, 0, 24'h123456, 24'h0, 5'h1F, 5'hF, 5'h3);
      vt[16] = mk(0, 0,      32'h0,         0, 0, 0, 0, 0, 24'h123456, 24'h0, 5'h1F, 5'hF, 5'h3);

      rst_n = 1'b0;
      drv(0, 0, 0, 0, 0);
      repeat (3) tick();
      chk("reset", {req, done, busy, timeout_err, out_carrier_fcws, out_mod_fcw,
                    out_mod_shift, out_note_en, out_synth_shift}, '0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 17; i++) begin
         drv(vt[i].we, int'(vt[i].addr), vt[i].data, vt[i].cm, vt[i].ak);
         tick();
         chk($sformatf("vec%0d", i),
             {req, done, busy, out_carrier_fcws[FW-1:0], out_mod_fcw, out_mod_shift,
              out_note_en, out_synth_shift},
             {vt[i].e_req, vt[i].e_done, vt[i].e_busy, vt[i].e_c0, vt[i].e_mfcw,
              vt[i].e_msh, vt[i].e_note, vt[i].e_ssh});
      end

      // Commit while in REQ, write mod_fcw during REL: queued second transfer.
      drv(0, 0, 0, 1, 0); tick();
      chk("A_req_up", {req, out_mod_fcw}, {1'b1, 24'h0});
      drv(0, 0, 0, 1, 0); tick();
      chk("A_pending_busy", {req, busy, out_mod_fcw}, {1'b1, 1'b1, 24'h0});
      drv(0, 0, 0, 0, 1); tick();
      chk("A_rel", req, 0);
      drv(1, NV, 32'h00AB_CDEF, 0, 1); tick();
      chk("A_held_stable", {req, done, out_mod_fcw}, {1'b0, 1'b0, 24'h0});
      drv(0, 0, 0, 0, 0); tick();
      chk("A_done1", {req, done, busy, out_mod_fcw}, {1'b0, 1'b1, 1'b1, 24'h0});
      tick();
      chk("A_second_req", {req, done, out_mod_fcw}, {1'b1, 1'b0, 24'hABCDEF});
      drv(0, 0, 0, 0, 1); tick();
      drv(0, 0, 0, 0, 0); tick();
      chk("A_done2", {done, busy}, {1'b1, 1'b0});
      tick();
      chk("A_idle", {done, busy, req}, 3'b000);

      // Three commits inside one transfer coalesce into a single extra one.
      r1 = 0; r2 = 0; pd = 0; dcnt = 0; rcnt = 0; dbl = 0;
      for (int c = 0; c < 30; c++) begin
         drv(0, 0, 0, (c == 0 || c == 2 || c == 3 || c == 4), r2);
         tick();
         if (done) dcnt++;
         if (done && pd) dbl++;
         if (req && !r1) rcnt++;
         pd = done; r2 = r1; r1 = req;
      end
      chk("B_done_pulses", 128'(dcnt), 128'd2);
      chk("B_req_rises", 128'(rcnt), 128'd2);
      chk("B_done_single", 128'(dbl), 128'd0);
      chk("B_busy_end", busy, 0);

      // Reset for one cycle in REQ.
      drv(0, 0, 0, 1, 0); tick();
      chk("C_in_req", req, 1);
      rst_n = 1'b0; drv(0, 0, 0, 0, 0); tick();
      chk("C_reset", {req, done, busy, out_carrier_fcws, out_mod_fcw, out_mod_shift,
                      out_note_en, out_synth_shift}, '0);
      rst_n = 1'b1; tick();
      chk("C_no_done", {req, done, busy}, 3'b000);
      drv(0, 0, 0, 1, 0); tick();
      chk("C_shadows_cleared", {req, out_carrier_fcws[FW-1:0], out_note_en}, {1'b1, 24'h0, 5'h0});
      drv(0, 0, 0, 0, 1); tick();
      drv(0, 0, 0, 0, 0); tick();
      chk("C_done", done, 1);
      drv(1, 0, 32'h0000_0055, 1, 0); tick();
      chk("C_same_cycle_write", {req, out_carrier_fcws[FW-1:0]}, {1'b1, 24'h000055});
      drv(0, 0, 0, 0, 1); tick();
      drv(0, 0, 0, 0, 0); tick();
      chk("C_done_after", {done, busy}, 2'b10);
      tick();

`ifdef SYNTH_STAGE_TIMEOUT_EN
      drv(0, 0, 0, 1, 0); tick();
      drv(0, 0, 0, 0, 0);
      cnt = 0; saw_done = 0;
      while (req && cnt < 40) begin
         cnt++;
         tick();
         if (done) saw_done = 1;
      end
      chk("D_req_cycles", 128'(cnt), 128'd16);
      chk("D_timeout_err", {timeout_err, busy, saw_done}, 3'b100);
      drv(0, 0, 0, 0, 1); repeat (3) tick();
      drv(0, 0, 0, 0, 0); repeat (3) tick();
      chk("D_sticky", {timeout_err, req, done, out_carrier_fcws[FW-1:0]}, {3'b100, 24'h000055});
`else
      drv(0, 0, 0, 1, 0); tick();
      drv(0, 0, 0, 0, 0);
      saw_done = 0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (done) saw_done = 1;
      end
      chk("D_waits", {req, busy, timeout_err, saw_done}, 4'b1100);
      drv(0, 0, 0, 0, 1); tick();
      drv(0, 0, 0, 0, 0); tick();
      chk("D_late_ack_done", {done, timeout_err}, 2'b10);
      cnt = 0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/synth_param_stager.md
# synth_param_stager

Single-clock, CPU-domain staging block for synthesizer parameters, generalised to N_VOICES voices with configurable FCW and shift widths. CPU writes land in shadow registers through an addressed write port; a commit snapshots all shadows into held output registers and runs a four-phase req/ack handshake toward the CPU-to-synth CDC. Held outputs never change while a transfer is in flight. Commits issued during a transfer are queued, not lost.

## Interface
- N_VOICES, 4, voice count (1..32)
- FCW_W, 24, carrier/modulator FCW width
- SHIFT_W, 5, mod_shift and synth_shift width
- TIMEOUT_CYCLES, 1024, ack watchdog limit (used only with SYNTH_STAGE_TIMEOUT_EN)
- ADDR_W, $clog2(N_VOICES+4), derived; not overridden

- clk  in  1  CPU clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- wr_en  in  1  shadow register write strobe
- wr_addr  in  ADDR_W  shadow register select
- wr_data  in  32  write data, LSB-aligned
- commit  in  1  one-cycle pulse: snapshot shadows and transfer
- ack  in  1  CDC acknowledge, already synchronized into clk
- req  out  1  CDC request, level
- out_carrier_fcws  out  N_VOICES*FCW_W  held carrier FCWs, voice i at bits [i*FCW_W +: FCW_W]
- out_mod_fcw  out  FCW_W  held modulator FCW
- out_mod_shift  out  SHIFT_W  held modulator shift
- out_note_en  out  N_VOICES  held note enables
- out_synth_shift  out  SHIFT_W  held output shift
- busy  out  1  high whenever state ≠ IDLE or a commit is pending
- done  out  1  one-cycle pulse at handshake completion
- timeout_err  out  1  sticky watchdog error

## Operation
- Address map: 0..N_VOICES-1 carrier FCW of voice addr; N_VOICES mod_fcw; N_VOICES+1 mod_shift; N_VOICES+2 note_en; N_VOICES+3 synth_shift. Writes take wr_data[field_width-1:0]; upper bits ignored. Out-of-range addresses ignored.
- Shadows are writable in every state.
- FSM states:
  - IDLE: on commit or pending, copy shadows into held outputs, clear pending, go to REQ.
  - REQ: req=1; wait for ack=1, then go to REL.
  - REL: req=0; wait for ack=0, then pulse done and go to IDLE.
- commit in REQ/REL sets pending, which is a single flag; multiple commits coalesce. In IDLE the pending flag triggers a new transfer using the shadow contents current at that cycle.
- A write and a commit in the same cycle in IDLE: the snapshot includes the new write data.
- Held outputs change only on the IDLE→REQ transition.
- Reset, including mid-transfer: state IDLE, req=0, pending=0, done=0, timeout_err=0, all shadows and held outputs 0.

## Timing
- commit in IDLE at cycle t: held outputs valid and req=1 at t+1.
- ack first sampled high at u: req=0 at u+1.
- ack sampled low at v (in REL): done=1 and state IDLE at v+1. If pending is set, req=1 again at v+2.
- Minimum transfer with ack following req with 0 delay: 3 cycles commit-to-done.
- ack high while in IDLE is ignored.

## Configuration
- SYNTH_STAGE_TIMEOUT_EN defined:
  - A counter runs in REQ and REL and clears on each state change.
  - On reaching TIMEOUT_CYCLES: req=0, go to IDLE next cycle, set timeout_err (sticky until reset), clear pending, no done pulse.
  - Held outputs keep their values.
- Undefined: no counter; timeout_err is tied to 0; the block waits indefinitely on ack.

## Test plan
- Reset, then write addr 0 = 0x123456 and addr N_VOICES+2 = 0xF, then commit; model ack 2 cycles after req -> out_carrier_fcws[23:0]=0x123456, out_note_en=0xF, req rises at t+1, done is a single pulse, busy returns to 0.
- commit while in REQ, with a write to addr N_VOICES = 0xABCDEF during REL -> second transfer starts at v+2 with out_mod_fcw=0xABCDEF; held outputs stable throughout the first handshake.
- Three commits during one transfer -> exactly one extra transfer and two done pulses total.
- Write to addr N_VOICES+4 with wr_data=0xFFFFFFFF -> no shadow change; write wr_data=0xFFFFFFFF to addr N_VOICES+1 -> out_mod_shift=0x1F after commit.
- Assert rst_n=0 for 1 cycle during REQ -> req=0, outputs 0, no done; a subsequent commit works normally.
- With SYNTH_STAGE_TIMEOUT_EN and TIMEOUT_CYCLES=16, hold ack=0 -> req drops after 16 cycles in REQ, timeout_err=1 stays set, done stays 0.
